// File: rtl/mul_div_unit_pkg.sv
// Shared op codes and state encodings for the
// iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_md_step.sv
// One iteration of shift-add multiply (mode=0)
// or restoring shift-subtract divide (mode=1).
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             mode,
  input  logic             bit_in,
  output logic [WIDTH-1:0] acc_next,
  output logic             qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  assign sum     = {1'b0, acc}
                 + (bit_in ? {1'b0, operand}
                           : {(WIDTH+1){1'b0}});
  assign shifted = {acc, bit_in};
  assign ge      = shifted >= {1'b0, operand};

  // a successful subtract always leaves a remainder below 2^WIDTH
  always_comb begin
    acc_next = sum[WIDTH:1];
    qbit     = sum[0];
    if (mode) begin
      acc_next = ge ? shifted[WIDTH-1:0] - operand
                    : shifted[WIDTH-1:0];
      qbit     = ge;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers,
// MTHI/MTLO writes and a flush cancel path.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH-1);

  md_state_e state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, lo_w, opd, a_orig;
  logic             is_div, neg_res, neg_rem, dz;

  logic             is_mul_op, is_div_op, is_sgn;
  logic             mthi_w, mtlo_w, go;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0] acc_nx, lo_nx;
  logic             qbit, bit_in;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   hi_res, lo_res;

  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    is_sgn    = 1'b0;
    mthi_w    = 1'b0;
    mtlo_w    = 1'b0;
    unique case (1'b1)
      op == MD_MULT:  begin
        is_mul_op = 1'b1;
        is_sgn    = 1'b1;
      end
      op == MD_MULTU: is_mul_op = 1'b1;
      op == MD_DIV:   begin
        is_div_op = 1'b1;
        is_sgn    = 1'b1;
      end
      op == MD_DIVU:  is_div_op = 1'b1;
      op == MD_MTHI:  mthi_w = 1'b1;
      op == MD_MTLO:  mtlo_w = 1'b1;
      default: ;
    endcase
  end

  // cancel wins over a simultaneous start
  assign go    = start && !cancel
              && (state == MD_IDLE);
  assign busy  = state != MD_IDLE;

  assign a_neg = is_sgn & a[WIDTH-1];
  assign b_neg = is_sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign bit_in = is_div ? lo_w[WIDTH-1] : lo_w[0];
  assign lo_nx  = is_div
                ? {lo_w[WIDTH-2:0], qbit}
                : {qbit, lo_w[WIDTH-1:1]};

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opd),
    .mode     (is_div),
    .bit_in   (bit_in),
    .acc_next (acc_nx),
    .qbit     (qbit)
  );

  assign prod   = {acc, lo_w};
  assign prod_s = neg_res ? -prod : prod;

  always_comb begin
    hi_res = prod_s[2*WIDTH-1:WIDTH];
    lo_res = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        hi_res = a_orig;
        lo_res = '1;
      end else begin
        hi_res = neg_rem ? -acc  : acc;
        lo_res = neg_res ? -lo_w : lo_w;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MD_IDLE:
        if (go && (is_mul_op || is_div_op))
          state_nx = MD_RUN;
      MD_RUN:
        if (cancel)
          state_nx = MD_IDLE;
        else if (cnt == LAST)
          state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      lo_w    <= '0;
      opd     <= '0;
      a_orig  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_IDLE: if (go) begin
          if (mthi_w) hi <= a;
          if (mtlo_w) lo <= a;
          if (is_mul_op || is_div_op) begin
            cnt     <= '0;
            acc     <= '0;
            is_div  <= is_div_op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz      <= is_div_op && (b == '0);
            a_orig  <= a;
            opd     <= is_div_op ? b_mag : a_mag;
            lo_w    <= is_div_op ? a_mag : b_mag;
          end
        end
        MD_RUN: if (!cancel) begin
          acc  <= acc_nx;
          lo_w <= lo_nx;
          cnt  <= cnt + CNT_W'(1);
        end
        MD_FIX: if (!cancel) begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks for mul_div_unit: vector table
// plus hand-written multi-cycle sequences.
module tb_mul_div_unit;

  localparam logic [2:0] T_MULT  = 3'd0;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // called #1 after a posedge; returns #1 after E0
  task automatic launch(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int edges,
                           output int bcyc);
    edges = 0;
    bcyc = 0;
    while (!done && edges < 100) begin
      if (busy) bcyc++;
      @(posedge clock);
      #1;
      edges++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: no done after %0d edges",
               edges);
    end
  endtask

  initial begin
    int ed, bc, seen;

    tbl[0] = '{"multu_max", T_MULTU, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{"mult_neg", T_MULT, 32'hFFFFFFFD,
               32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[2] = '{"div_neg", T_DIV, 32'hFFFFFFF9,
               32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{"divu_7_2", T_DIVU, 32'd7,
               32'd2, 32'd1, 32'd3};
    tbl[4] = '{"divu_by0", T_DIVU, 32'h0000000A,
               32'd0, 32'h0000000A, 32'hFFFFFFFF};
    tbl[5] = '{"div_ovf", T_DIV, 32'h80000000,
               32'hFFFFFFFF, 32'd0, 32'h80000000};
    tbl[6] = '{"div_by0_neg", T_DIV, 32'hFFFFFFF0,
               32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF};
    tbl[7] = '{"div_pos_neg", T_DIV, 32'd7,
               32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tbl[8] = '{"mult_m1_m1", T_MULT, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'd0, 32'd1};
    tbl[9] = '{"multu_2p32", T_MULTU, 32'h00010000,
               32'h00010000, 32'd1, 32'd0};

    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    #9 reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(ed, bc);
      chk({tbl[i].name, "_lat"}, ed, 32'd33);
      chk({tbl[i].name, "_busy"}, bc, 32'd33);
      chk({tbl[i].name, "_hi"}, hi, tbl[i].hi);
      chk({tbl[i].name, "_lo"}, lo, tbl[i].lo);
      @(posedge clock);
      #1;
      chk({tbl[i].name, "_pulse"},
          {31'd0, done}, 32'd0);
    end

    launch(T_MTHI, 32'h12345678, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    launch(T_MTLO, 32'hCAFEF00D, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'h12345678);
    launch(3'd7, 32'h1, 32'h1);
    chk("undef_busy", {31'd0, busy}, 32'd0);
    chk("undef_hi", hi, 32'h12345678);
    chk("undef_lo", lo, 32'hCAFEF00D);

    launch(T_MULTU, 32'd2, 32'd3);
    repeat (4) @(posedge clock);
    #1;
    op = T_MULTU;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(ed, bc);
    chk("ign_lat", ed, 32'd28);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd6);
    @(posedge clock);
    #1;
    chk("ign_idle", {31'd0, busy}, 32'd0);

    launch(T_MTHI, 32'd0, 32'd0);
    launch(T_MTLO, 32'd0, 32'd0);
    launch(T_MULTU, 32'd5, 32'd5);
    repeat (9) @(posedge clock);
    #1;
    cancel = 1'b1;
    @(posedge clock);
    #1;
    cancel = 1'b0;
    chk("cxl_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) seen++;
    end
    chk("cxl_nodone", seen, 32'd0);
    chk("cxl_hi", hi, 32'd0);
    chk("cxl_lo", lo, 32'd0);

    launch(T_MULTU, 32'd3, 32'd4);
    wait_done(ed, bc);
    chk("b2b_first_lo", lo, 32'd12);
    launch(T_DIVU, 32'd12, 32'd5);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(ed, bc);
    chk("b2b_lat", ed, 32'd33);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd2);

    launch(T_MTHI, 32'h55, 32'd0);
    launch(T_MTLO, 32'hAA, 32'd0);
    launch(T_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    launch(T_DIVU, 32'd100, 32'd7);
    wait_done(ed, bc);
    chk("post_lat", ed, 32'd33);
    chk("post_hi", hi, 32'd2);
    chk("post_lo", lo, 32'd14);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU and is started by a one-cycle handshake. The control unit stalls on busy and reads hi/lo for MFHI/MFLO.
- Parametrised in operand width, with a cancel path for pipeline flushes.

Parameters:
- WIDTH, 32, operand width and width of each of hi and lo. Must be even and at least 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived; do not override.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  3  operation code (see shared constants).
- a  input  WIDTH  dividend / multiplicand / MTHI/MTLO source.
- b  input  WIDTH  divisor / multiplier.
- cancel  input  1  abort the in-flight operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo are updated by a mult/div.
- hi  output  WIDTH  HI register: product upper half / remainder.
- lo  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards all work immediately.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and hi/lo write.
- IDLE with start=1, on clock edge E0:
  - Latch op, |a| and |b|. Use magnitudes only for signed ops.
  - Latch the result-sign flags.
  - Clear the counter and go to RUN.
  - Set busy=1.
- IDLE with start=1 and op=MTHI or MTLO:
  - hi (or lo) = a at E0.
  - Stay in IDLE; busy and done stay 0.
- Undefined op codes with start=1: no effect.
- RUN, multiply: shift-add, one multiplier bit per cycle.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN length and exit: the counter increments each cycle; after WIDTH edges (E1..E_WIDTH) go to FIX.
- FIX at edge E_WIDTH+1:
  - Apply negation: product and quotient are negative iff the operand signs differ; the remainder takes the dividend's sign.
  - Write hi/lo, busy=0, done=1 for exactly the following cycle, return to IDLE.
- Latency: start accepted at E0 → hi/lo valid and done=1 after E_WIDTH+1 (WIDTH+1 cycles). busy is high from after E0 until E_WIDTH+1.
- Back-to-back operation: start may be asserted in the done cycle and is accepted.
- start while busy: ignored; no queueing.
- cancel=1 in RUN or FIX:
  - Return to IDLE at the next edge with busy=0.
  - hi/lo keep their pre-operation values; done is not asserted.
- cancel in IDLE: no effect. cancel has priority over start at the same edge.
- Divide by zero (b=0), signed or unsigned: hi=a (original, unnegated), lo=all ones. Timing is identical to a normal divide.
- Signed overflow (DIV of most-negative by -1): lo=most-negative, hi=0 (two's-complement wrap). Not flagged.
- Arithmetic: product is 2*WIDTH bits exact, hi=[2W-1:W], lo=[W-1:0]. Internal accumulators are WIDTH+1 bits for the divide subtraction.
- Result independence: hi/lo never change except on MTHI/MTLO, the FIX write, or reset. Inputs a, b and op are don't-care after E0.

Decomposition:
- constants.h gets:
  - MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - State encodings: MD_IDLE, MD_RUN, MD_FIX.
- One sub-module, md_step: a combinational single-iteration step. Inputs are the accumulator, the operand and a mode bit; outputs are the next accumulator and the quotient bit. mul_div_unit keeps the FSM, counter, sign handling and hi/lo registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=2: lo=3, hi=1.
- DIVU a=0x0000000A b=0: hi=0x0000000A, lo=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI a=0x12345678: hi=0x12345678 after one edge, busy=0, done=0.
- Then MULTU 2*3 with a second start at cycle 5: second start ignored; hi=0, lo=6.
- MULTU 5*5 after hi=lo=0, with cancel at cycle 10: busy=0 next cycle, no done pulse, hi=lo=0.
- Reset raised mid-RUN at cycle 10, off a clock edge: busy=0, hi=lo=0 immediately. After release, DIVU 100/7 gives lo=14, hi=2.
